// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between the memory stage and the dreq/dresp bus.
// Stalls the pipeline while a load/store is in flight and lane-aligns data.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_write,
    input  logic [2:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    input  logic              pipe_advance,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              mem_stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q;
    state_t      state_d;
    logic        drop_q;
    logic [31:0] cnt_q;
    logic        inflight;
    logic        start;
    logic        squash;
    logic        to_hit;
    logic [2:0]  lane;
    logic [7:0]  strobe_d;

    assign inflight = (state_q == REQ) || (state_q == WAIT);
    assign start    = (state_q == IDLE) && mem_valid && !flush;
    assign squash   = drop_q || flush;
    assign lane     = mem_addr[2:0];
    assign to_hit   = (TIMEOUT != 0) && inflight &&
                      (cnt_q == 32'(TIMEOUT - 1));

    always_comb begin
        strobe_d = 8'h00;
        if (mem_write) begin
            case (mem_size)
                3'd0:    strobe_d = 8'h01 << lane;
                3'd1:    strobe_d = 8'h03 << lane;
                3'd2:    strobe_d = 8'h0F << lane;
                default: strobe_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ: begin
                if (dresp_data_ok) state_d = squash ? IDLE : DONE;
                else if (dresp_addr_ok) state_d = WAIT;
            end
            WAIT: if (dresp_data_ok) state_d = squash ? IDLE : DONE;
            DONE: if (pipe_advance || flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dreq_valid  = inflight;
        rdata_valid = (state_q == DONE);
        mem_stall   = start || inflight;
    end

    // Request fields, drop flag, timeout counter and captured read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dreq_addr   <= '0;
            dreq_size   <= '0;
            dreq_strobe <= '0;
            dreq_data   <= '0;
            rdata       <= '0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            err         <= 1'b0;
        end else begin
            if (start) begin
                dreq_addr   <= mem_addr;
                dreq_size   <= mem_size;
                dreq_strobe <= strobe_d;
                dreq_data   <= mem_wdata << {lane, 3'b000};
            end
            if (inflight && dresp_data_ok) begin
                rdata <= dresp_data >> {dreq_addr[2:0], 3'b000};
            end
            if (inflight) begin
                drop_q <= squash && !dresp_data_ok;
            end else begin
                drop_q <= 1'b0;
            end
            if (inflight && !dresp_data_ok) begin
                cnt_q <= cnt_q + 32'd1;
            end else begin
                cnt_q <= '0;
            end
            if (to_hit) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: vector table plus flush,
// timeout and mid-transaction reset sequences.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        flush;
    logic        pipe_advance;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        mem_stall;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W(64),
        .DATA_W(64),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_valid(mem_valid),
        .mem_write(mem_write),
        .mem_size(mem_size),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .flush(flush),
        .pipe_advance(pipe_advance),
        .dreq_valid(dreq_valid),
        .dreq_addr(dreq_addr),
        .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .mem_stall(mem_stall),
        .rdata(rdata),
        .rdata_valid(rdata_valid),
        .err(err)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] resp;
        int          aok;
        int          dok;
        logic [7:0]  strb;
        logic [63:0] dout;
        logic [63:0] rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_valid     = 1'b0;
        mem_write     = 1'b0;
        mem_size      = 3'd0;
        mem_addr      = '0;
        mem_wdata     = '0;
        flush         = 1'b0;
        pipe_advance  = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stalls;
        string tag;
        tag = $sformatf("v%0d", idx);
        step();
        mem_valid = 1'b1;
        mem_write = v.wr;
        mem_size  = v.size;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        #1;
        stalls = int'(mem_stall);
        chk({tag, "_idle_dreq_valid"}, 64'(dreq_valid), 64'd0);
        for (int k = 1; k <= v.dok; k++) begin
            step();
            dresp_addr_ok = (k == v.aok);
            dresp_data_ok = (k == v.dok);
            dresp_data    = v.resp;
            #1;
            stalls += int'(mem_stall);
            chk({tag, "_dreq_valid"}, 64'(dreq_valid), 64'd1);
            if (k == 1) begin
                chk({tag, "_addr"}, dreq_addr, v.addr);
                chk({tag, "_size"}, 64'(dreq_size), 64'(v.size));
                chk({tag, "_strobe"}, 64'(dreq_strobe), 64'(v.strb));
                chk({tag, "_wdata"}, dreq_data, v.dout);
            end
        end
        step();
        idle_inputs();
        pipe_advance = 1'b1;
        #1;
        chk({tag, "_stall_cycles"}, 64'(stalls), 64'(v.dok + 1));
        chk({tag, "_done_stall"}, 64'(mem_stall), 64'd0);
        chk({tag, "_done_rvalid"}, 64'(rdata_valid), 64'd1);
        chk({tag, "_done_dreq_valid"}, 64'(dreq_valid), 64'd0);
        if (!v.wr) chk({tag, "_rdata"}, rdata, v.rd);
        step();
        pipe_advance = 1'b0;
        #1;
        chk({tag, "_after_rvalid"}, 64'(rdata_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 3'd3, 64'h80000010, 64'h0,
                    64'h1122334455667788, 0, 3,
                    8'h00, 64'h0, 64'h1122334455667788};
        vecs[1] = '{1'b1, 3'd0, 64'h80000005, 64'hAB,
                    64'h0, 1, 2,
                    8'h20, 64'h0000AB0000000000, 64'h0};
        vecs[2] = '{1'b0, 3'd1, 64'h80000006, 64'h0,
                    64'hBEEF000000000000, 1, 2,
                    8'h00, 64'h0, 64'h000000000000BEEF};
        vecs[3] = '{1'b1, 3'd1, 64'h80000003, 64'h1234,
                    64'h0, 0, 1,
                    8'h18, 64'h0000001234000000, 64'h0};
        vecs[4] = '{1'b1, 3'd2, 64'h80000006, 64'hDEADBEEF,
                    64'h0, 1, 1,
                    8'hC0, 64'hBEEF000000000000, 64'h0};
        vecs[5] = '{1'b1, 3'd3, 64'h80000001, 64'h0102030405060708,
                    64'h0, 2, 4,
                    8'hFF, 64'h0203040506070800, 64'h0};
        vecs[6] = '{1'b0, 3'd0, 64'h80000007, 64'h0,
                    64'h5A00000000000000, 0, 1,
                    8'h00, 64'h0, 64'h000000000000005A};
        vecs[7] = '{1'b0, 3'd2, 64'h80000004, 64'h0,
                    64'hCAFEBABE12345678, 0, 2,
                    8'h00, 64'h0, 64'h00000000CAFEBABE};

        idle_inputs();
        reset = 1'b0;
        step();
        step();
        #1;
        chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst_stall", 64'(mem_stall), 64'd0);
        chk("rst_rvalid", 64'(rdata_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_strobe", 64'(dreq_strobe), 64'd0);
        chk("rst_addr", dreq_addr, 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // flush in IDLE: nothing starts
        step();
        mem_valid = 1'b1;
        mem_addr  = 64'h200;
        flush     = 1'b1;
        #1;
        chk("fidle_stall", 64'(mem_stall), 64'd0);
        step();
        idle_inputs();
        #1;
        chk("fidle_dreq_valid", 64'(dreq_valid), 64'd0);

        // flush while in WAIT: bus completes, result dropped
        step();
        mem_valid = 1'b1;
        mem_addr  = 64'h100;
        mem_size  = 3'd3;
        step();
        dresp_addr_ok = 1'b1;
        step();
        dresp_addr_ok = 1'b0;
        flush = 1'b1;
        mem_valid = 1'b0;
        #1;
        chk("fwait_dreq_valid0", 64'(dreq_valid), 64'd1);
        for (int k = 0; k < 2; k++) begin
            step();
            flush = 1'b0;
            #1;
            chk("fwait_dreq_valid", 64'(dreq_valid), 64'd1);
            chk("fwait_rvalid", 64'(rdata_valid), 64'd0);
        end
        step();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h7777;
        step();
        idle_inputs();
        #1;
        chk("fwait_end_rvalid", 64'(rdata_valid), 64'd0);
        chk("fwait_end_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("fwait_end_stall", 64'(mem_stall), 64'd0);
        step();
        #1;
        chk("fwait_end2_rvalid", 64'(rdata_valid), 64'd0);
        run_vec(vecs[2], 8);

        // timeout: no response for 10 in-flight cycles
        step();
        mem_valid = 1'b1;
        mem_addr  = 64'h300;
        mem_size  = 3'd3;
        for (int k = 1; k <= 10; k++) begin
            step();
            #1;
            if (k == 7) chk("to_err_early", 64'(err), 64'd0);
            if (k >= 9) chk("to_err_set", 64'(err), 64'd1);
            chk("to_dreq_valid", 64'(dreq_valid), 64'd1);
        end
        step();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h42;
        step();
        idle_inputs();
        pipe_advance = 1'b1;
        #1;
        chk("to_done_rvalid", 64'(rdata_valid), 64'd1);
        chk("to_done_rdata", rdata, 64'h42);
        step();
        pipe_advance = 1'b0;
        #1;
        chk("to_err_sticky", 64'(err), 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("to_err_cleared", 64'(err), 64'd0);

        // reset while in REQ, then a stray data_ok
        step();
        mem_valid = 1'b1;
        mem_addr  = 64'h400;
        step();
        #1;
        chk("rr_req_valid", 64'(dreq_valid), 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        mem_valid = 1'b0;
        #1;
        chk("rr_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rr_stall", 64'(mem_stall), 64'd0);
        chk("rr_addr", dreq_addr, 64'd0);
        step();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h99;
        step();
        dresp_data_ok = 1'b0;
        #1;
        chk("rr_stray_rvalid", 64'(rdata_valid), 64'd0);
        chk("rr_stray_rdata", rdata, 64'd0);
        chk("rr_stray_dreq_valid", 64'(dreq_valid), 64'd0);
        step();
        #1;
        chk("rr_stray_rvalid2", 64'(rdata_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences every data-memory transaction issued by the memory stage over the dreq/dresp bus. It raises the stall that freezes the EX/MEM and MEM/WB pipeline registers while a load or store is in flight, and it formats write strobes and write data. It aligns read data and holds it until the pipeline advances. It sits between the memory stage and the data-bus interface.

Parameters:
ADDR_W, 64, data address width
DATA_W, 64, bus data width; fixed at 64 (8 byte lanes)
TIMEOUT, 1024, cycles in flight before err sets; 0 disables the check

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low; reset==0 at a rising clk edge resets the block
mem_valid  in  1  memory stage holds a load/store this cycle
mem_write  in  1  1=store, 0=load
mem_size  in  3  0=byte, 1=half, 2=word, 3=dword
mem_addr  in  ADDR_W  byte address
mem_wdata  in  64  store data, right-aligned
flush  in  1  jump/redirect; the current memory-stage instruction is squashed
pipe_advance  in  1  pipeline registers load this cycle (no other stall source)
dreq_valid  out  1  bus request valid
dreq_addr  out  ADDR_W  request address
dreq_size  out  3  request size
dreq_strobe  out  8  byte write enables, 0 for loads
dreq_data  out  64  lane-shifted store data
dresp_addr_ok  in  1  bus accepted address
dresp_data_ok  in  1  transaction complete
dresp_data  in  64  raw read data
mem_stall  out  1  handshake stall to pipeline registers
rdata  out  64  load data shifted right by addr[2:0]*8, not sign-extended
rdata_valid  out  1  rdata valid (state DONE)
err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset: state=IDLE, dreq_valid=0, all dreq_* fields=0, rdata=0, rdata_valid=0, err=0, timeout counter=0.
- IDLE, mem_valid=1 and flush=0:
  - Register addr, size, strobe and shifted data.
  - Next state REQ.
  - mem_stall=1 combinationally in that same cycle.
- IDLE, otherwise: mem_stall=0; remain in IDLE.
- Strobe (stores only, computed from addr[2:0], truncated to 8 bits):
  - size0: 8'h01 << a
  - size1: 8'h03 << a
  - size2: 8'h0F << a
  - size3: 8'hFF
  - dreq_data = mem_wdata << (a*8).
- REQ:
  - dreq_valid=1; all fields stable.
  - data_ok → DONE, regardless of addr_ok.
  - addr_ok without data_ok → WAIT.
  - Neither → remain in REQ.
- WAIT: dreq_valid stays 1 (bus holds valid until data_ok); data_ok → DONE.
- On the data_ok cycle: rdata ← dresp_data >> (addr[2:0]*8); captured for stores as well (don't-care value).
- DONE:
  - dreq_valid=0, rdata_valid=1, mem_stall=0.
  - pipe_advance=1 → IDLE next cycle; otherwise hold rdata.
  - In DONE, a new mem_valid is not sampled; the next request starts from IDLE one cycle after the advance.
- mem_stall = (IDLE & mem_valid & !flush) | REQ | WAIT.
- flush:
  - In IDLE: no request is started.
  - In REQ/WAIT: the bus is never aborted. A drop flag is set; on data_ok go to IDLE (not DONE), rdata_valid stays 0, and drop clears.
  - In DONE: go to IDLE next cycle.
- Timeout:
  - Counter increments each cycle in REQ/WAIT and clears on leaving them.
  - At count==TIMEOUT-1 in REQ/WAIT, err sets and stays set until reset. The transaction still waits.
- Reset mid-transaction: IDLE next edge, dreq_valid=0; a later stray data_ok in IDLE is ignored.

Test Plan:
- Load dword at addr 0x80000010; data_ok 3 cycles after valid, resp 0x1122334455667788 → mem_stall high 4 cycles, rdata=0x1122334455667788, rdata_valid one cycle with pipe_advance=1.
- Store byte 0xAB at addr 0x...05 → dreq_strobe=8'h20, dreq_data=0x0000AB0000000000, dreq_valid held until data_ok.
- Load half at addr 0x...06 with resp 0xBEEF000000000000 → rdata=0x000000000000BEEF; addr_ok one cycle before data_ok shows REQ→WAIT→DONE.
- flush asserted in WAIT → dreq_valid held to data_ok, then IDLE, rdata_valid never 1, next request starts normally.
- TIMEOUT=8, no data_ok for 10 cycles → err=1 at the 8th in-flight cycle, stays 1 after completion until reset=0.
- reset=0 while in REQ → dreq_valid=0 and mem_stall=0 next cycle; data_ok pulse afterwards produces no rdata_valid.
